// File: rtl/local_injector_pkg.sv
// Shared types and helpers for the local injection port: flit and channel
// vector widths, the starvation counter action, and the priority-select helper.
package local_injector_pkg;

  localparam int WIDTH_PORT  = 16;
  localparam int NUM_CHANNEL = 5;

  typedef logic [WIDTH_PORT-1:0]  flit_t;
  typedef logic [NUM_CHANNEL-1:0] chan_vec_t;

  // What the starvation counter does at the next edge.
  typedef enum logic [1:0] {
    STARVE_CLEAR = 2'd0,
    STARVE_INC   = 2'd1,
    STARVE_HOLD  = 2'd2
  } starve_action_e;

  // Keeps only the lowest set bit of v; bit 0 has the highest priority.
  function automatic chan_vec_t lowest_set(input chan_vec_t v);
    chan_vec_t sel;
    sel = '0;
    for (int i = NUM_CHANNEL - 1; i >= 0; i--) begin
      if (v[i]) begin
        sel    = '0;
        sel[i] = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/local_injector_fifo.sv
// Synchronous DEPTH-entry flit FIFO for the injection port. The head entry is
// visible combinationally; push is ignored when full and pop is ignored when empty.
module inject_fifo
  import local_injector_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  flit_t                  push_data,
  input  logic                   pop,
  output flit_t                  head,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

  flit_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always_ff blocks are evaluated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries are unreachable until written,
  // and leaving them unreset lets the array map onto plain RAM/flops without a reset tree.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head      = mem[rd_ptr];
  assign occupancy = count;

endmodule

// File: rtl/local_injector.sv
// Injection side of the router local port: buffers PE flits and offers the head
// flit to the lowest-index free output channel, flagging starvation when blocked.
module local_injector
  import local_injector_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   peValid,
  input  flit_t                  peFlit,
  output logic                   peReady,
  input  chan_vec_t              freeVector,
  output chan_vec_t              injVector,
  output flit_t                  injFlit,
  output logic                   starve,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  flit_t            head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  chan_vec_t        grant;
  logic [CNT_W-1:0] starve_cnt;
  starve_action_e   starve_action;

  // peReady comes from registered state only, so a pop in the same cycle
  // never opens room for a push while full.
  assign peReady = ~fifo_full;
  assign push    = peValid & peReady;

  inject_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (peFlit),
    .pop       (pop),
    .head      (head),
    .occupancy (occupancy),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // One-hot grant to the lowest free channel; no same-cycle bypass from peFlit.
  assign grant     = fifo_empty ? '0 : lowest_set(freeVector);
  assign injVector = grant;
  assign injFlit   = (grant != '0) ? head : '0;
  assign pop       = (grant != '0);

  // NOTE: every signal written in this always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    starve_action = STARVE_CLEAR;
    if (!fifo_empty && freeVector == '0) begin
      starve_action = (starve_cnt == LIMIT) ? STARVE_HOLD : STARVE_INC;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else begin
      case (starve_action)
        STARVE_INC:  starve_cnt <= starve_cnt + CNT_ONE;
        STARVE_HOLD: starve_cnt <= starve_cnt;
        default:     starve_cnt <= '0;
      endcase
    end
  end

  assign starve = (starve_cnt == LIMIT);

endmodule
